// File: rtl/pll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pll_ctrl
//  Brief    : rPLL bring-up sequencer with lock qualification, retry/fail,
//             and a runtime phase/duty change handshake with settle window.
//  Revision : 1.0
// ============================================================================
module pll_ctrl #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE   = 1024,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter logic [3:0]  PSDA_INIT     = 4'b0000,
    parameter logic [3:0]  DUTY_INIT     = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [3:0] pll_psda,
    output logic [3:0] pll_dutyda,
    input  logic       cfg_valid,
    input  logic [3:0] cfg_psda,
    input  logic [3:0] cfg_dutyda,
    output logic       cfg_ready,
    output logic       sys_rst_n,
    output logic       clk_en,
    output logic       locked,
    output logic       fail,
    output logic [3:0] retries
);

    // One shared counter serves the reset, timeout and settle phases, so it
    // is sized for the largest of the three terminal counts.
    localparam int unsigned C_MAX_AB  = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int unsigned C_CNT_MAX = (C_MAX_AB > RST_CYCLES) ? C_MAX_AB : RST_CYCLES;
    localparam int unsigned C_CNT_W   = $clog2(C_CNT_MAX + 1);

    localparam logic [C_CNT_W-1:0] C_CNT_ONE      = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_RST_LAST     = C_CNT_W'(RST_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_SETTLE_LAST  = C_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_LOCK_STABLE  = C_CNT_W'(LOCK_STABLE);
    localparam logic [C_CNT_W-1:0] C_LOCK_TIMEOUT = C_CNT_W'(LOCK_TIMEOUT);
    localparam logic [3:0]         C_MAX_RETRIES  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RUN       = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_CNT_W-1:0]   w_cnt_next;
    logic [C_CNT_W-1:0]   w_cnt_inc;
    logic [C_CNT_W-1:0]   r_stable;
    logic [C_CNT_W-1:0]   w_stable_next;
    logic [C_CNT_W-1:0]   w_stable_inc;
    logic [3:0]           w_retries_inc;
    logic [3:0]           w_retries_next;
    logic [3:0]           w_psda_next;
    logic [3:0]           w_duty_next;
    logic                 r_lock_meta;
    logic                 r_lock_s;
    logic                 w_pll_reset_next;
    logic                 w_sys_rst_n_next;
    logic                 w_clk_en_next;
    logic                 w_locked_next;
    logic                 w_fail_next;
    logic                 w_cfg_ready_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_state     <= ST_RESET;
            r_cnt       <= '0;
            r_stable    <= '0;
            retries     <= 4'd0;
            pll_psda    <= PSDA_INIT;
            pll_dutyda  <= DUTY_INIT;
            pll_reset   <= 1'b1;
            sys_rst_n   <= 1'b0;
            clk_en      <= 1'b0;
            locked      <= 1'b0;
            fail        <= 1'b0;
            cfg_ready   <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_stable    <= w_stable_next;
            retries     <= w_retries_next;
            pll_psda    <= w_psda_next;
            pll_dutyda  <= w_duty_next;
            pll_reset   <= w_pll_reset_next;
            sys_rst_n   <= w_sys_rst_n_next;
            clk_en      <= w_clk_en_next;
            locked      <= w_locked_next;
            fail        <= w_fail_next;
            cfg_ready   <= w_cfg_ready_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_stable_next  = '0;
        w_retries_next = retries;
        w_psda_next    = pll_psda;
        w_duty_next    = pll_dutyda;
        w_cnt_inc      = r_cnt + C_CNT_ONE;
        w_stable_inc   = r_lock_s ? (r_stable + C_CNT_ONE) : '0;
        w_retries_inc  = (retries == 4'hF) ? 4'hF : (retries + 4'd1);

        case (r_state)
            ST_RESET: begin
                if (r_cnt == C_RST_LAST) begin
                    w_state_next = ST_WAIT_LOCK;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            ST_WAIT_LOCK: begin
                w_cnt_next    = w_cnt_inc;
                w_stable_next = w_stable_inc;
                // A qualified lock wins over a timeout landing on the same cycle.
                if (w_stable_inc == C_LOCK_STABLE) begin
                    w_state_next  = ST_RUN;
                    w_cnt_next    = '0;
                    w_stable_next = '0;
                end else if (w_cnt_inc == C_LOCK_TIMEOUT) begin
                    w_retries_next = w_retries_inc;
                    w_cnt_next     = '0;
                    w_stable_next  = '0;
                    w_state_next   = (w_retries_inc >= C_MAX_RETRIES) ? ST_FAIL : ST_RESET;
                end
            end
            ST_RUN: begin
                if (!r_lock_s) begin
                    w_state_next = ST_RESET;
                    w_cnt_next   = '0;
                end else if (cfg_valid && cfg_ready) begin
                    w_psda_next  = cfg_psda;
                    w_duty_next  = cfg_dutyda;
                    w_state_next = ST_SETTLE;
                    w_cnt_next   = '0;
                end
            end
            ST_SETTLE: begin
                if (!r_lock_s) begin
                    w_state_next = ST_RESET;
                    w_cnt_next   = '0;
                end else if (r_cnt == C_SETTLE_LAST) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            ST_FAIL: begin
                w_state_next = ST_FAIL;
            end
            default: begin
                w_state_next = ST_RESET;
                w_cnt_next   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they flip on the same
        // edge as the state register while still coming straight off flops.
        w_pll_reset_next = (w_state_next == ST_RESET) || (w_state_next == ST_FAIL);
        w_sys_rst_n_next = (w_state_next == ST_RUN) || (w_state_next == ST_SETTLE);
        w_clk_en_next    = (w_state_next == ST_RUN);
        w_locked_next    = (w_state_next == ST_RUN) || (w_state_next == ST_SETTLE);
        w_fail_next      = (w_state_next == ST_FAIL);
        w_cfg_ready_next = (w_state_next == ST_RUN);
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pll_ctrl
//  Brief    : Scoreboard bench for pll_ctrl: bring-up, glitch, retry/fail,
//             phase change, lock loss and mid-operation reset.
//  Revision : 1.0
// ============================================================================
module tb_pll_ctrl;

    localparam int unsigned RST_CYC  = 16;
    localparam int unsigned STABLE   = 1024;
    localparam int unsigned TIMEOUT  = 4000;
    localparam int unsigned RETRIES  = 3;
    localparam int unsigned SETTLE   = 64;

    localparam int S_RESET  = 0;
    localparam int S_WAIT   = 1;
    localparam int S_RUN    = 2;
    localparam int S_SETTLE = 3;
    localparam int S_FAIL   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [3:0] cfg_psda = 4'h0;
    logic [3:0] cfg_dutyda = 4'h0;
    logic       pll_reset;
    logic [3:0] pll_psda;
    logic [3:0] pll_dutyda;
    logic       cfg_ready;
    logic       sys_rst_n;
    logic       clk_en;
    logic       locked;
    logic       fail;
    logic [3:0] retries;

    pll_ctrl #(
        .RST_CYCLES    (RST_CYC),
        .LOCK_STABLE   (STABLE),
        .LOCK_TIMEOUT  (TIMEOUT),
        .MAX_RETRIES   (RETRIES),
        .SETTLE_CYCLES (SETTLE),
        .PSDA_INIT     (4'b0000),
        .DUTY_INIT     (4'b1000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .pll_psda   (pll_psda),
        .pll_dutyda (pll_dutyda),
        .cfg_valid  (cfg_valid),
        .cfg_psda   (cfg_psda),
        .cfg_dutyda (cfg_dutyda),
        .cfg_ready  (cfg_ready),
        .sys_rst_n  (sys_rst_n),
        .clk_en     (clk_en),
        .locked     (locked),
        .fail       (fail),
        .retries    (retries)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {pll_reset, sys_rst_n, clk_en, locked, fail, cfg_ready, retries, psda, duty}
    logic [17:0] obs;
    assign obs = {pll_reset, sys_rst_n, clk_en, locked, fail, cfg_ready,
                  retries, pll_psda, pll_dutyda};

    int unsigned q_at[$];
    logic [17:0] q_exp[$];
    string       q_name[$];
    int          checks = 0;
    int          errors = 0;

    int unsigned m_at;
    logic [17:0] m_exp;
    string       m_name;

    always @(negedge clk) begin
        while (q_at.size() > 0 && q_at[0] <= cyc) begin
            m_at   = q_at.pop_front();
            m_exp  = q_exp.pop_front();
            m_name = q_name.pop_front();
            checks++;
            if (m_at != cyc) begin
                errors++;
                $display("FAIL %s: compared at cycle %0d, scheduled for %0d", m_name, cyc, m_at);
            end else if (obs !== m_exp) begin
                errors++;
                $display("FAIL %s @cycle %0d: got %h, expected %h", m_name, cyc, obs, m_exp);
            end
        end
    end

    function automatic logic [17:0] vec(int st, logic [3:0] rt, logic [3:0] ps, logic [3:0] du);
        logic pr, srn, ce, lk, fl, rdy;
        pr  = (st == S_RESET) || (st == S_FAIL);
        srn = (st == S_RUN) || (st == S_SETTLE);
        ce  = (st == S_RUN);
        lk  = (st == S_RUN) || (st == S_SETTLE);
        fl  = (st == S_FAIL);
        rdy = (st == S_RUN);
        return {pr, srn, ce, lk, fl, rdy, rt, ps, du};
    endfunction

    task automatic expect_at(input int unsigned at, input string name, input logic [17:0] e);
        q_at.push_back(at);
        q_exp.push_back(e);
        q_name.push_back(name);
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called on a negedge: rst_n low for two edges, released, then checks the
    // 16-cycle pll_reset pulse that follows.
    task automatic apply_reset(output int unsigned rel);
        int unsigned c;
        c = cyc;
        rst_n = 1'b0;
        expect_at(c + 1, "rst_values", vec(S_RESET, 4'd0, 4'h0, 4'h8));
        expect_at(c + 2, "rst_hold", vec(S_RESET, 4'd0, 4'h0, 4'h8));
        wait_cyc(c + 2);
        rst_n = 1'b1;
        rel = c + 2;
        expect_at(rel + RST_CYC - 1, "pll_reset_last", vec(S_RESET, 4'd0, 4'h0, 4'h8));
        expect_at(rel + RST_CYC, "pll_reset_fall", vec(S_WAIT, 4'd0, 4'h0, 4'h8));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r, t, a, b, c2, d, g, f, w, last;
        @(negedge clk);

        // Clean bring-up
        apply_reset(r);
        t = r + RST_CYC + 100;
        wait_cyc(t);
        pll_lock = 1'b1;
        expect_at(t + STABLE + 1, "pre_release", vec(S_WAIT, 4'd0, 4'h0, 4'h8));
        expect_at(t + STABLE + 2, "release", vec(S_RUN, 4'd0, 4'h0, 4'h8));
        wait_cyc(t + STABLE + 6);

        // Phase/duty change, with a request during SETTLE that must be ignored
        a = cyc;
        cfg_valid = 1'b1; cfg_psda = 4'h5; cfg_dutyda = 4'h6;
        expect_at(a + 1, "cfg_accept", vec(S_SETTLE, 4'd0, 4'h5, 4'h6));
        expect_at(a + SETTLE, "settle_last", vec(S_SETTLE, 4'd0, 4'h5, 4'h6));
        expect_at(a + SETTLE + 1, "settle_done", vec(S_RUN, 4'd0, 4'h5, 4'h6));
        wait_cyc(a + 1);
        cfg_valid = 1'b0;
        wait_cyc(a + 10);
        cfg_valid = 1'b1; cfg_psda = 4'h9; cfg_dutyda = 4'hA;
        wait_cyc(a + 20);
        cfg_valid = 1'b0;
        wait_cyc(a + SETTLE + 6);

        // Lock loss during SETTLE with cfg_valid held
        b = cyc;
        cfg_valid = 1'b1; cfg_psda = 4'h3; cfg_dutyda = 4'h2;
        expect_at(b + 1, "accept2", vec(S_SETTLE, 4'd0, 4'h3, 4'h2));
        wait_cyc(b + 1);
        cfg_psda = 4'h9; cfg_dutyda = 4'hA;
        wait_cyc(b + 5);
        pll_lock = 1'b0;
        expect_at(b + 7, "settle_pre_loss", vec(S_SETTLE, 4'd0, 4'h3, 4'h2));
        expect_at(b + 8, "loss_to_reset", vec(S_RESET, 4'd0, 4'h3, 4'h2));
        expect_at(b + 8 + RST_CYC - 1, "loss_rst_last", vec(S_RESET, 4'd0, 4'h3, 4'h2));
        expect_at(b + 8 + RST_CYC, "loss_wait", vec(S_WAIT, 4'd0, 4'h3, 4'h2));
        wait_cyc(b + 10);
        cfg_valid = 1'b0;
        wait_cyc(b + 30);
        pll_lock = 1'b1;
        c2 = b + 30;
        expect_at(c2 + STABLE + 2, "relock", vec(S_RUN, 4'd0, 4'h3, 4'h2));
        wait_cyc(c2 + STABLE + 6);

        // Lock loss in RUN coinciding with a cfg request: loss wins
        d = cyc;
        pll_lock = 1'b0;
        expect_at(d + 2, "run_pre_loss", vec(S_RUN, 4'd0, 4'h3, 4'h2));
        expect_at(d + 3, "loss_beats_cfg", vec(S_RESET, 4'd0, 4'h3, 4'h2));
        wait_cyc(d + 2);
        cfg_valid = 1'b1; cfg_psda = 4'hF; cfg_dutyda = 4'h1;
        wait_cyc(d + 3);
        cfg_valid = 1'b0;

        // Glitchy lock: one-cycle drop at stable count 500
        g = d + 3 + RST_CYC + 100;
        wait_cyc(g);
        pll_lock = 1'b1;
        expect_at(g + STABLE + 2, "no_early_release", vec(S_WAIT, 4'd0, 4'h3, 4'h2));
        wait_cyc(g + 502);
        pll_lock = 1'b0;
        wait_cyc(g + 503);
        pll_lock = 1'b1;
        f = g + 503;
        expect_at(f + STABLE + 1, "glitch_pre_release", vec(S_WAIT, 4'd0, 4'h3, 4'h2));
        expect_at(f + STABLE + 2, "glitch_release", vec(S_RUN, 4'd0, 4'h3, 4'h2));
        wait_cyc(f + STABLE + 6);

        // rst_n in RUN, then rst_n in WAIT_LOCK
        pll_lock = 1'b0;
        apply_reset(r);
        wait_cyc(r + RST_CYC + 50);
        apply_reset(r);

        // Never lock: three timeouts, then FAIL (cfg ignored there)
        w = r + RST_CYC;
        for (int k = 0; k < 3; k++) begin
            expect_at(w + TIMEOUT - 1, "attempt_end", vec(S_WAIT, 4'(k), 4'h0, 4'h8));
            if (k < 2) begin
                expect_at(w + TIMEOUT, "retry_reset", vec(S_RESET, 4'(k + 1), 4'h0, 4'h8));
                expect_at(w + TIMEOUT + RST_CYC - 1, "retry_rst_last", vec(S_RESET, 4'(k + 1), 4'h0, 4'h8));
                expect_at(w + TIMEOUT + RST_CYC, "retry_wait", vec(S_WAIT, 4'(k + 1), 4'h0, 4'h8));
                w = w + TIMEOUT + RST_CYC;
            end else begin
                expect_at(w + TIMEOUT, "fail_enter", vec(S_FAIL, 4'd3, 4'h0, 4'h8));
                expect_at(w + TIMEOUT + 100, "fail_hold", vec(S_FAIL, 4'd3, 4'h0, 4'h8));
            end
        end
        wait_cyc(w + TIMEOUT + 10);
        cfg_valid = 1'b1; cfg_psda = 4'h7; cfg_dutyda = 4'h7;
        wait_cyc(w + TIMEOUT + 50);
        cfg_valid = 1'b0;
        wait_cyc(w + TIMEOUT + 105);

        // Reset out of FAIL clears fail and retries
        apply_reset(r);
        last = r + RST_CYC;
        wait_cyc(last + 3);

        if (q_at.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q_at.size());
            errors += q_at.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
